// File: rtl/mem_arb_pkg.sv
// Shared types and the read re-assembly helper for the data memory arbiter.
package mem_arb_pkg;

  typedef enum logic [0:0] {
    S_CPU      = 1'b0,
    S_AUX_LOCK = 1'b1
  } arb_state_t;

  typedef enum logic [0:0] {
    SZ_BYTE = 1'b0,
    SZ_HALF = 1'b1
  } size_t;

  typedef enum logic [0:0] {
    P_CPU = 1'b0,
    P_AUX = 1'b1
  } port_t;

  // Rebuilds a little-endian value from the two bank bytes; the low byte sits in the odd bank for odd addresses.
  function automatic logic [15:0] assembleRead(input logic half, input logic a0,
                                               input logic [7:0] evenByte, input logic [7:0] oddByte);
    logic [15:0] data;
    if (half) begin
      data = a0 ? {evenByte, oddByte} : {oddByte, evenByte};
    end else begin
      data = {8'h00, (a0 ? oddByte : evenByte)};
    end
    return data;
  endfunction

endpackage

// File: rtl/mem_bank_steer.sv
// Combinational steering of one granted access onto the even/odd byte banks,
// plus re-assembly of the bank read data for the returning read.
module mem_bank_steer
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              reqValid,
  input  logic [ADDR_W-1:0] reqAddr,
  input  logic              reqWe,
  input  logic              reqSize,
  input  logic [15:0]       reqWdata,
  input  logic              retValid,
  input  logic              retA0,
  input  logic              retSize,
  input  logic [7:0]        even_rdata,
  input  logic [7:0]        odd_rdata,
  output logic [ADDR_W-2:0] even_addr,
  output logic [ADDR_W-2:0] odd_addr,
  output logic              even_we,
  output logic              odd_we,
  output logic [7:0]        even_wdata,
  output logic [7:0]        odd_wdata,
  output logic [15:0]       rdata
);

  localparam int BA_W = ADDR_W - 1;
  localparam logic [BA_W-1:0] BA_ONE = {{(BA_W-1){1'b0}}, 1'b1};

  logic [BA_W-1:0] bankAddr_s;
  logic [BA_W-1:0] bankAddrInc_s;
  logic            isHalf_s;

  assign bankAddr_s    = reqAddr[ADDR_W-1:1];
  assign bankAddrInc_s = bankAddr_s + BA_ONE;  // wraps at the top of the bank
  assign isHalf_s      = (size_t'(reqSize) == SZ_HALF);

  // Lane/address/write-enable steering for the granted access.
  always_comb begin
    even_addr  = {BA_W{1'b0}};
    odd_addr   = {BA_W{1'b0}};
    even_we    = 1'b0;
    odd_we     = 1'b0;
    even_wdata = 8'h00;
    odd_wdata  = 8'h00;
    if (reqValid) begin
      if (!reqAddr[0]) begin
        even_addr  = bankAddr_s;
        odd_addr   = bankAddr_s;
        even_wdata = reqWdata[7:0];
        odd_wdata  = reqWdata[15:8];
        even_we    = reqWe;
        odd_we     = reqWe & isHalf_s;
      end else begin
        // Odd halfword straddles: high byte lives in the next even word.
        odd_addr   = bankAddr_s;
        even_addr  = isHalf_s ? bankAddrInc_s : bankAddr_s;
        odd_wdata  = reqWdata[7:0];
        even_wdata = reqWdata[15:8];
        odd_we     = reqWe;
        even_we    = reqWe & isHalf_s;
      end
    end else begin
      even_we = 1'b0;
      odd_we  = 1'b0;
    end
  end

  // Read data is only driven while a read is returning.
  always_comb begin
    rdata = 16'h0000;
    if (retValid) begin
      rdata = assembleRead(retSize, retA0, even_rdata, odd_rdata);
    end else begin
      rdata = 16'h0000;
    end
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares the byte-banked data memory between the cpu MEM stage and an auxiliary
// master: one grant per cycle, starvation relief for aux, bounded aux locking.
module data_memory_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int STARVE_LIMIT = 8,
  parameter int MAX_LOCK     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_we,
  input  logic              cpu_size,
  input  logic [15:0]       cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  input  logic              aux_req,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic              aux_we,
  input  logic              aux_size,
  input  logic [15:0]       aux_wdata,
  input  logic              aux_lock,
  output logic              aux_gnt,
  output logic              aux_rvalid,
  output logic [15:0]       rdata,
  output logic [ADDR_W-2:0] even_addr,
  output logic [ADDR_W-2:0] odd_addr,
  output logic              even_we,
  output logic              odd_we,
  output logic [7:0]        even_wdata,
  output logic [7:0]        odd_wdata,
  input  logic [7:0]        even_rdata,
  input  logic [7:0]        odd_rdata
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam int LOCK_W   = $clog2(MAX_LOCK + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
  localparam logic [STARVE_W-1:0] STARVE_ONE = {{(STARVE_W-1){1'b0}}, 1'b1};
  localparam logic [LOCK_W-1:0]   LOCK_LAST  = LOCK_W'(MAX_LOCK - 1);
  localparam logic [LOCK_W-1:0]   LOCK_ONE   = {{(LOCK_W-1){1'b0}}, 1'b1};

  arb_state_t          state_r;
  arb_state_t          stateNext_s;
  logic [STARVE_W-1:0] starveCnt_r;
  logic [LOCK_W-1:0]   lockCnt_r;
  logic                starveFull_s;
  logic                lockLast_s;
  logic                cpuGnt_s;
  logic                auxGnt_s;
  logic                gntAny_s;
  port_t               reqPort_s;
  logic [ADDR_W-1:0]   reqAddr_s;
  logic                reqWe_s;
  logic                reqSize_s;
  logic [15:0]         reqWdata_s;
  logic                cpuRvalid_r;
  logic                auxRvalid_r;
  logic                retA0_r;
  logic                retSize_r;

  assign starveFull_s = (starveCnt_r == STARVE_MAX);
  // The beat granted while lockCnt sits one below the cap is the final locked beat.
  assign lockLast_s   = (lockCnt_r >= LOCK_LAST);
  assign gntAny_s     = cpuGnt_s | auxGnt_s;

  // Arbiter state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_CPU;
    end else begin
      state_r <= stateNext_s;
    end
  end

  // Next-state logic: enter lock on a locked aux grant, leave when the burst ends or hits the cap.
  always_comb begin
    stateNext_s = state_r;
    case (state_r)
      S_CPU: begin
        if (auxGnt_s && aux_lock) begin
          stateNext_s = S_AUX_LOCK;
        end else begin
          stateNext_s = S_CPU;
        end
      end
      S_AUX_LOCK: begin
        if (!aux_req || !aux_lock || lockLast_s) begin
          stateNext_s = S_CPU;
        end else begin
          stateNext_s = S_AUX_LOCK;
        end
      end
      default: stateNext_s = S_CPU;
    endcase
  end

  // Grant logic; reset suppresses every grant immediately.
  always_comb begin
    cpuGnt_s = 1'b0;
    auxGnt_s = 1'b0;
    if (reset) begin
      cpuGnt_s = 1'b0;
      auxGnt_s = 1'b0;
    end else begin
      case (state_r)
        S_CPU: begin
          if (cpu_req && !(aux_req && starveFull_s)) begin
            cpuGnt_s = 1'b1;
          end else if (aux_req) begin
            auxGnt_s = 1'b1;
          end else begin
            cpuGnt_s = 1'b0;
            auxGnt_s = 1'b0;
          end
        end
        S_AUX_LOCK: auxGnt_s = aux_req;
        default: begin
          cpuGnt_s = 1'b0;
          auxGnt_s = 1'b0;
        end
      endcase
    end
  end

  // Consecutive aux beats within the current lock burst.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lockCnt_r <= {LOCK_W{1'b0}};
    end else if (stateNext_s == S_AUX_LOCK) begin
      lockCnt_r <= (state_r == S_CPU) ? LOCK_ONE : lockCnt_r + LOCK_ONE;
    end else begin
      lockCnt_r <= {LOCK_W{1'b0}};
    end
  end

  // Saturating count of cycles aux has waited while requesting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starveCnt_r <= {STARVE_W{1'b0}};
    end else if (aux_req && !auxGnt_s) begin
      starveCnt_r <= starveFull_s ? starveCnt_r : starveCnt_r + STARVE_ONE;
    end else begin
      starveCnt_r <= {STARVE_W{1'b0}};
    end
  end

  // Select the granted port's request for the bank steering.
  always_comb begin
    reqPort_s  = P_CPU;
    reqAddr_s  = cpu_addr;
    reqWe_s    = cpu_we;
    reqSize_s  = cpu_size;
    reqWdata_s = cpu_wdata;
    if (auxGnt_s) begin
      reqPort_s = P_AUX;
    end else begin
      reqPort_s = P_CPU;
    end
    case (reqPort_s)
      P_AUX: begin
        reqAddr_s  = aux_addr;
        reqWe_s    = aux_we;
        reqSize_s  = aux_size;
        reqWdata_s = aux_wdata;
      end
      default: begin
        reqAddr_s  = cpu_addr;
        reqWe_s    = cpu_we;
        reqSize_s  = cpu_size;
        reqWdata_s = cpu_wdata;
      end
    endcase
  end

  // Read return pipe: which port gets rvalid next cycle and how to rebuild its data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpuRvalid_r <= 1'b0;
      auxRvalid_r <= 1'b0;
      retA0_r     <= 1'b0;
      retSize_r   <= 1'b0;
    end else begin
      cpuRvalid_r <= cpuGnt_s & ~cpu_we;
      auxRvalid_r <= auxGnt_s & ~aux_we;
      if (gntAny_s) begin
        retA0_r   <= reqAddr_s[0];
        retSize_r <= reqSize_s;
      end
    end
  end

  mem_bank_steer #(
    .ADDR_W(ADDR_W)
  ) uSteer (
    .reqValid  (gntAny_s),
    .reqAddr   (reqAddr_s),
    .reqWe     (reqWe_s),
    .reqSize   (reqSize_s),
    .reqWdata  (reqWdata_s),
    .retValid  (cpuRvalid_r | auxRvalid_r),
    .retA0     (retA0_r),
    .retSize   (retSize_r),
    .even_rdata(even_rdata),
    .odd_rdata (odd_rdata),
    .even_addr (even_addr),
    .odd_addr  (odd_addr),
    .even_we   (even_we),
    .odd_we    (odd_we),
    .even_wdata(even_wdata),
    .odd_wdata (odd_wdata),
    .rdata     (rdata)
  );

  assign cpu_gnt    = cpuGnt_s;
  assign aux_gnt    = auxGnt_s;
  assign cpu_stall  = cpu_req & ~cpuGnt_s;
  assign cpu_rvalid = cpuRvalid_r;
  assign aux_rvalid = auxRvalid_r;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Self-checking bench for data_memory_arbiter: a byte-addressed memory model and
// a request-level arbitration model, directed scenarios, then random traffic.
module tb_data_memory_arbiter;

  localparam int ADDR_W = 16;
  localparam int STARVE = 8;
  localparam int MAXL   = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_size;
  logic [15:0] cpu_addr, cpu_wdata;
  logic        cpu_gnt, cpu_stall, cpu_rvalid;
  logic        aux_req, aux_we, aux_size, aux_lock;
  logic [15:0] aux_addr, aux_wdata;
  logic        aux_gnt, aux_rvalid;
  logic [15:0] rdata;
  logic [14:0] even_addr, odd_addr;
  logic        even_we, odd_we;
  logic [7:0]  even_wdata, odd_wdata, even_rdata, odd_rdata;

  always #5 clk = ~clk;

  data_memory_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(STARVE), .MAX_LOCK(MAXL)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_size(cpu_size),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid),
    .aux_req(aux_req), .aux_addr(aux_addr), .aux_we(aux_we), .aux_size(aux_size),
    .aux_wdata(aux_wdata), .aux_lock(aux_lock), .aux_gnt(aux_gnt), .aux_rvalid(aux_rvalid),
    .rdata(rdata), .even_addr(even_addr), .odd_addr(odd_addr), .even_we(even_we),
    .odd_we(odd_we), .even_wdata(even_wdata), .odd_wdata(odd_wdata),
    .even_rdata(even_rdata), .odd_rdata(odd_rdata)
  );

  function automatic logic [7:0] initByte(input logic [15:0] a);
    return a[7:0] ^ {a[14:8], a[15]} ^ 8'h3C;
  endfunction

  // Physical banks with synchronous read.
  logic [7:0] evenMem [0:32767];
  logic [7:0] oddMem  [0:32767];
  bit         evenWr  [0:32767];
  bit         oddWr   [0:32767];
  always @(posedge clk) begin
    even_rdata <= evenWr[even_addr] ? evenMem[even_addr] : initByte({even_addr, 1'b0});
    odd_rdata  <= oddWr[odd_addr]   ? oddMem[odd_addr]   : initByte({odd_addr, 1'b1});
    if (even_we) begin evenMem[even_addr] <= even_wdata; evenWr[even_addr] <= 1'b1; end
    if (odd_we)  begin oddMem[odd_addr]   <= odd_wdata;  oddWr[odd_addr]   <= 1'b1; end
  end

  // Reference model: flat byte memory plus request-level arbitration bookkeeping.
  logic [7:0]  refMem [0:65535];
  bit          refWr  [0:65535];
  int          mStarve, mLockBeats;
  bit          pendValid, pendPort;
  logic [15:0] pendData;
  logic        eCpu, eAux;
  int          errors = 0;
  int          checks = 0;

  function automatic logic [7:0] refByte(input logic [15:0] a);
    return refWr[a] ? refMem[a] : initByte(a);
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mStarve = 0; mLockBeats = 0; pendValid = 1'b0; pendPort = 1'b0; pendData = 16'h0000;
  endtask

  // Compare phase: predict this cycle's grants/returns and check the DUT, away from the rising edge.
  task automatic evalCycle();
    logic [15:0] gA;
    logic gWe, gHalf, gAny;
    @(negedge clk); #1;
    eCpu = 1'b0; eAux = 1'b0;
    if (mLockBeats > 0) eAux = aux_req;
    else if (cpu_req && !(aux_req && mStarve >= STARVE)) eCpu = 1'b1;
    else if (aux_req) eAux = 1'b1;
    gAny  = eCpu | eAux;
    gA    = eAux ? aux_addr : cpu_addr;
    gWe   = eAux ? aux_we : cpu_we;
    gHalf = eAux ? aux_size : cpu_size;
    chk1("cpu_gnt", cpu_gnt, eCpu);
    chk1("aux_gnt", aux_gnt, eAux);
    chk1("cpu_stall", cpu_stall, cpu_req && !eCpu);
    chk1("cpu_rvalid", cpu_rvalid, pendValid && !pendPort);
    chk1("aux_rvalid", aux_rvalid, pendValid && pendPort);
    chk16("rdata", rdata, pendValid ? pendData : 16'h0000);
    chk1("even_we", even_we, gAny && gWe && (!gA[0] || gHalf));
    chk1("odd_we", odd_we, gAny && gWe && (gA[0] || gHalf));
  endtask

  // Update phase: commit the predicted grant into the model at the rising edge.
  task automatic advance();
    logic [15:0] gA, gA1, gD;
    logic gWe, gHalf, gAny;
    @(posedge clk);
    gAny  = eCpu | eAux;
    gA    = eAux ? aux_addr : cpu_addr;
    gA1   = gA + 16'h0001;
    gD    = eAux ? aux_wdata : cpu_wdata;
    gWe   = eAux ? aux_we : cpu_we;
    gHalf = eAux ? aux_size : cpu_size;
    pendValid = gAny && !gWe;
    pendPort  = eAux;
    pendData  = gHalf ? {refByte(gA1), refByte(gA)} : {8'h00, refByte(gA)};
    if (gAny && gWe) begin
      refMem[gA] = gD[7:0]; refWr[gA] = 1'b1;
      if (gHalf) begin refMem[gA1] = gD[15:8]; refWr[gA1] = 1'b1; end
    end
    if (eAux) begin
      if (mLockBeats == 0) mLockBeats = aux_lock ? 1 : 0;
      else begin
        mLockBeats++;
        if (!aux_lock || mLockBeats >= MAXL) mLockBeats = 0;
      end
    end else if (mLockBeats > 0) mLockBeats = 0;
    if (aux_req && !eAux) begin
      if (mStarve < STARVE) mStarve++;
    end else mStarve = 0;
    #1;
  endtask

  task automatic step();
    evalCycle();
    advance();
  endtask

  function automatic logic [15:0] randAddr();
    if ($urandom_range(0, 7) == 0) return 16'hFFF8 | 16'($urandom_range(0, 7));
    return 16'($urandom_range(0, 31));
  endfunction

  task automatic newCpu();
    cpu_req = ($urandom_range(0, 99) < 85);
    cpu_addr = randAddr(); cpu_we = ($urandom_range(0, 2) == 0);
    cpu_size = 1'($urandom_range(0, 1)); cpu_wdata = 16'($urandom);
  endtask

  task automatic newAux();
    aux_req = ($urandom_range(0, 9) < 5); aux_lock = ($urandom_range(0, 2) == 0);
    aux_addr = randAddr(); aux_we = ($urandom_range(0, 2) == 0);
    aux_size = 1'($urandom_range(0, 1)); aux_wdata = 16'($urandom);
  endtask

  initial begin
    int beats;
    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_size = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 16'h0000;
    aux_req = 1'b0; aux_we = 1'b0; aux_size = 1'b0; aux_addr = 16'h0000; aux_wdata = 16'h0000;
    aux_lock = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_cpu_gnt", cpu_gnt, 1'b0); chk1("rst_aux_gnt", aux_gnt, 1'b0);
    chk1("rst_cpu_rvalid", cpu_rvalid, 1'b0); chk1("rst_aux_rvalid", aux_rvalid, 1'b0);
    chk16("rst_rdata", rdata, 16'h0000);
    chk1("rst_even_we", even_we, 1'b0); chk1("rst_odd_we", odd_we, 1'b0);
    reset = 1'b0;
    step();

    // Reset in the middle of aux accesses.
    aux_req = 1'b1; aux_we = 1'b1; aux_size = 1'b1; aux_addr = 16'h0010; aux_wdata = 16'h1234;
    evalCycle();
    chk1("t1_we_before_rst", even_we, 1'b1);
    reset = 1'b1; #1;
    chk1("t1_even_we_rst", even_we, 1'b0); chk1("t1_odd_we_rst", odd_we, 1'b0);
    chk1("t1_aux_gnt_rst", aux_gnt, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0; modelReset();
    aux_we = 1'b0; aux_lock = 1'b1;
    evalCycle();
    reset = 1'b1;
    @(posedge clk); #1;
    chk1("t1_aux_rvalid_rst", aux_rvalid, 1'b0); chk16("t1_rdata_rst", rdata, 16'h0000);
    aux_req = 1'b0; aux_lock = 1'b0; reset = 1'b0; modelReset();
    step();
    cpu_req = 1'b1; aux_req = 1'b1; cpu_addr = 16'h0011;
    evalCycle(); chk1("t1_state_cpu", cpu_gnt, 1'b1); advance();
    cpu_req = 1'b0; aux_req = 1'b0;
    step(); step();

    // Starvation relief.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 1'b1; cpu_addr = 16'h0100;
    aux_req = 1'b1; aux_we = 1'b0; aux_size = 1'b0; aux_addr = 16'h0101; aux_lock = 1'b0;
    for (int k = 0; k < 10; k++) begin
      evalCycle();
      chk1("t2_cpu_gnt", cpu_gnt, k != 8);
      chk1("t2_aux_gnt", aux_gnt, k == 8);
      if (k == 8) chk1("t2_cpu_stall", cpu_stall, 1'b1);
      advance();
      if (eAux) aux_req = 1'b0;
    end
    cpu_req = 1'b0;
    step(); step();

    // Straddling halfword write and read back.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = 1'b1; cpu_addr = 16'h0005; cpu_wdata = 16'hBEEF;
    evalCycle();
    chk1("t3_odd_we", odd_we, 1'b1); chk16("t3_odd_addr", {1'b0, odd_addr}, 16'h0002);
    chk16("t3_odd_wdata", {8'h00, odd_wdata}, 16'h00EF);
    chk1("t3_even_we", even_we, 1'b1); chk16("t3_even_addr", {1'b0, even_addr}, 16'h0003);
    chk16("t3_even_wdata", {8'h00, even_wdata}, 16'h00BE);
    advance();
    cpu_we = 1'b0; step(); cpu_req = 1'b0;
    evalCycle(); chk1("t3_rvalid", cpu_rvalid, 1'b1); chk16("t3_rdata", rdata, 16'hBEEF); advance();

    // Odd byte write then read.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = 1'b0; cpu_addr = 16'h0003; cpu_wdata = 16'h117A;
    step();
    cpu_we = 1'b0;
    evalCycle();
    chk16("t5_even_addr", {1'b0, even_addr}, 16'h0001); chk16("t5_odd_addr", {1'b0, odd_addr}, 16'h0001);
    advance(); cpu_req = 1'b0;
    evalCycle(); chk1("t5_rvalid", cpu_rvalid, 1'b1); chk16("t5_rdata", rdata, 16'h007A); advance();
    evalCycle(); chk1("t5_rvalid_once", cpu_rvalid, 1'b0); advance();

    // Halfword at the top address wraps the even bank.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = 1'b1; cpu_addr = 16'hFFFF; cpu_wdata = 16'hA55A;
    step();
    cpu_we = 1'b0;
    evalCycle();
    chk16("t6_even_addr", {1'b0, even_addr}, 16'h0000); chk16("t6_odd_addr", {1'b0, odd_addr}, 16'h7FFF);
    advance(); cpu_req = 1'b0;
    evalCycle(); chk16("t6_rdata", rdata, 16'hA55A); advance();

    // Aux lock burst capped while cpu waits.
    aux_req = 1'b1; aux_lock = 1'b1; aux_we = 1'b0; aux_size = 1'b0; aux_addr = 16'h0020;
    beats = 0;
    for (int k = 0; k < 7; k++) begin
      evalCycle();
      chk1("t4_aux_gnt", aux_gnt, k != 4);
      chk1("t4_cpu_gnt", cpu_gnt, k == 4);
      advance();
      if (k == 0) begin cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 1'b0; cpu_addr = 16'h0040; end
      if (k == 4) cpu_req = 1'b0;
      if (eAux) beats++;
      if (beats == 6) aux_req = 1'b0;
    end
    aux_lock = 1'b0;
    step(); step();

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      step();
      if (eCpu || !cpu_req) newCpu();
      if (eAux || !aux_req) newAux();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
